div_arbiter: RTL

Round-robin arbiter and sequencer that shares one 32-bit iterative restoring divider among N requesters. Each requester presents a dividend/divisor pair on a valid/ready handshake; the block grants one request at a time, drives the divider's level-sensitive start, waits for completion and returns quotient, remainder and an error flag on a single response channel tagged with the requester id. Divide-by-zero requests are answered directly without occupying the divider.

---
 rtl/div_arbiter_if.sv | 37 +++
 rtl/div_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_arbiter_if.sv
// Bundle of request, response and divider-side signals for div_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface div_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_q;
    logic [31:0]     rsp_r;
    logic            rsp_err;

    logic            div_start;
    logic [31:0]     div_a;
    logic [31:0]     div_b;
    logic [31:0]     div_q;
    logic [31:0]     div_r;
    logic            div_ok;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, div_q, div_r, div_ok,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, div_q, div_r, div_ok,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among N requesters.
// Divide-by-zero requests are answered directly without using the divider.
module div_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic         clk,
    input  logic         reset,
    div_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [31:0]    r_div_a;
    logic [31:0]    r_div_b;
    logic [31:0]    r_q;
    logic [31:0]    r_r;
    logic           r_err;

    logic [31:0]    w_a [N];
    logic [31:0]    w_b [N];
    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic [31:0]    w_sel_a;
    logic [31:0]    w_sel_b;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_a[g] = bus.req_a[32*g +: 32];
        assign w_b[g] = bus.req_b[32*g +: 32];
    end

    // Round-robin search: first valid requester at or after the pointer, wrapping mod N.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N)) begin
                w_sum = w_sum - (IDW+1)'(N);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
                w_winner = w_winner;
            end
        end
        w_sel_a = w_a[w_winner];
        w_sel_b = w_b[w_winner];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = (w_sel_b == 32'd0) ? S_RESP : S_LAUNCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   w_next = bus.div_ok ? S_RESP : S_WAIT;
            S_RESP:   w_next = bus.rsp_ready ? S_IDLE : S_RESP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; start stays high while the divider is busy so it never reloads on div_ok.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        bus.div_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    bus.req_ready = {{(N-1){1'b0}}, 1'b1} << w_winner;
                end else begin
                    bus.req_ready = '0;
                end
            end
            S_LAUNCH: bus.div_start = 1'b1;
            S_WAIT:   bus.div_start = !bus.div_ok;
            S_RESP:   bus.rsp_valid = 1'b1;
            default:  bus.div_start = 1'b0;
        endcase
    end

    // Operand, pointer and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_div_a <= 32'd0;
            r_div_b <= 32'd0;
            r_q     <= 32'd0;
            r_r     <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id  <= w_winner;
                        r_ptr <= (w_winner == IDW'(N - 1)) ? '0 : w_winner + IDW'(1);
                        if (w_sel_b == 32'd0) begin
                            r_q   <= 32'hFFFF_FFFF;
                            r_r   <= w_sel_a;
                            r_err <= 1'b1;
                        end else begin
                            r_div_a <= w_sel_a;
                            r_div_b <= w_sel_b;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.div_ok) begin
                        r_q   <= bus.div_q;
                        r_r   <= bus.div_r;
                        r_err <= 1'b0;
                    end
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    assign bus.rsp_id  = r_id;
    assign bus.rsp_q   = r_q;
    assign bus.rsp_r   = r_r;
    assign bus.rsp_err = r_err;
    assign bus.div_a   = r_div_a;
    assign bus.div_b   = r_div_b;

endmodule
